pc_gen: RTL

- Parametrised program-counter generator; successor to the fixed 32-bit single-mode PC register.
- Drives the instruction-fetch address under a valid/ready handshake to instruction memory.
- Resolves redirect sources (branch/jump, trap) by priority and latches redirects that arrive while fetch is stalled.
- Adds halt/resume control and misaligned-target detection.

---
 rtl/pc_gen.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program-counter generator with redirect/trap priority, stall-safe pending redirect and halt control
// Optional compressed-instruction support is enabled by defining PC_GEN_C_EXT_EN.
module pc_gen #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_target,
  input  logic            halt,
  input  logic            resume,
`ifdef PC_GEN_C_EXT_EN
  input  logic            inst_compressed,
`endif
  output logic [XLEN-1:0] pc,
  output logic            fetch_valid,
  output logic [XLEN-1:0] pc_plus,
  output logic            misalign_err,
  output logic [XLEN-1:0] misalign_addr
);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALTED
  } state_t;

  localparam logic [XLEN-1:0] STEP_WORD = XLEN'(4);

  state_t          state;
  logic            pending_valid;
  logic [XLEN-1:0] pending_target;
  logic            halt_pending;

  logic [XLEN-1:0] step;
  logic [XLEN-1:0] trap_aligned;
  logic            target_misaligned;
  logic            redirect_ok;
  logic            transfer;
  logic            halt_req;

`ifdef PC_GEN_C_EXT_EN
  localparam logic [XLEN-1:0] STEP_HALF  = XLEN'(2);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(1);

  always_comb begin
    step = STEP_WORD;
    if (inst_compressed) step = STEP_HALF;
  end
`else
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(3);

  always_comb begin
    step = STEP_WORD;
  end
`endif

  // Wraps modulo 2^XLEN by construction of the fixed-width add.
  assign pc_plus           = pc + step;
  assign trap_aligned      = trap_target & ~ALIGN_MASK;
  assign target_misaligned = |(redirect_target & ALIGN_MASK);
  assign redirect_ok       = redirect && !target_misaligned;
  assign transfer          = fetch_valid && fetch_ready;
  assign halt_req          = halt || halt_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_BOOT;
      pc             <= RESET_VEC;
      fetch_valid    <= 1'b0;
      pending_valid  <= 1'b0;
      pending_target <= '0;
      halt_pending   <= 1'b0;
      misalign_err   <= 1'b0;
      misalign_addr  <= '0;
    end else begin
      misalign_err <= 1'b0;
      if (redirect && target_misaligned) begin
        misalign_err  <= 1'b1;
        misalign_addr <= redirect_target;
      end

      case (state)
        ST_BOOT: begin
          state       <= ST_RUN;
          fetch_valid <= 1'b1;
          if (halt) halt_pending <= 1'b1;
          // No request is outstanding yet, so redirects apply directly.
          if (trap) begin
            pc            <= trap_aligned;
            pending_valid <= 1'b0;
          end else if (redirect_ok) begin
            pc            <= redirect_target;
            pending_valid <= 1'b0;
          end
        end

        ST_RUN: begin
          if (trap) begin
            pc            <= trap_aligned;
            pending_valid <= 1'b0;
          end else if (redirect_ok && transfer) begin
            pc            <= redirect_target;
            pending_valid <= 1'b0;
          end else if (redirect_ok) begin
            // Stalled: hold pc, remember the youngest redirect.
            pending_valid  <= 1'b1;
            pending_target <= redirect_target;
          end else if (transfer && pending_valid) begin
            pc            <= pending_target;
            pending_valid <= 1'b0;
          end else if (transfer) begin
            pc <= pc_plus;
          end

          // fetch_valid is always 1 in RUN, so "no outstanding request" is fetch_ready.
          if (halt_req && fetch_ready) begin
            state        <= ST_HALTED;
            fetch_valid  <= 1'b0;
            halt_pending <= 1'b0;
          end else if (halt) begin
            halt_pending <= 1'b1;
          end
        end

        ST_HALTED: begin
          if (trap) begin
            pc            <= trap_aligned;
            pending_valid <= 1'b0;
          end else if (redirect_ok) begin
            pc            <= redirect_target;
            pending_valid <= 1'b0;
          end else if (pending_valid) begin
            pc            <= pending_target;
            pending_valid <= 1'b0;
          end

          if (resume && !halt) begin
            state       <= ST_RUN;
            fetch_valid <= 1'b1;
          end
        end

        default: begin
          state       <= ST_BOOT;
          fetch_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
